ysyx_22040386_lsu: RTL and testbench
====================================

Name: ysyx_22040386_lsu

Overview:
- Load/store unit in the MEM stage; consumes the execute-stage outputs: ALU result as address, store data, MemRead/MemWrite, FUNCT3, and the writeback fields.
- Issues one access at a time to the data-memory bus over a valid/ready request and a valid response.
- Loads: aligns and sign/zero-extends the read data. Stores: generates byte strobes.
- Delivers the writeback bundle to WB over a valid/ready handshake.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus data width; fixed at 64, giving 8-byte lanes.

Ports:
- clk  in  1  clock. All registers update on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_in_valid  in  1  EX bundle valid.
- o_in_ready  out  1  LSU can accept a bundle.
- i_MemRead  in  1  load.
- i_MemWrite  in  1  store.
- i_FUNCT3  in  3  access size/sign.
- i_addr  in  64  effective address (ALU result).
- i_wr_data  in  64  store data (rs2).
- i_reg_wr_addr  in  5  destination register.
- i_RegWrite  in  1  writeback enable.
- i_reg_wr_data  in  64  writeback data for non-memory ops.
- o_mem_req_valid  out  1  bus request valid.
- i_mem_req_ready  in  1  bus accepts request.
- o_mem_wen  out  1  1=write.
- o_mem_addr  out  64  {i_addr[63:3],3'b0}.
- o_mem_wdata  out  64  lane-aligned store data.
- o_mem_wstrb  out  8  byte strobes; 0 for reads.
- i_mem_resp_valid  in  1  response (read data or write ack).
- i_mem_rdata  in  64  read data, 8-byte aligned.
- o_out_valid  out  1  WB bundle valid.
- i_out_ready  in  1  WB accepts the bundle.
- o_reg_wr_addr  out  5  destination register.
- o_RegWrite  out  1  writeback enable.
- o_reg_wr_data  out  64  load result or pass-through data.
- o_lsu_fault  out  1  misaligned or unsupported access; valid with o_out_valid.

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset puts the FSM in IDLE and sets every registered output to 0.
- o_in_ready = (state==IDLE) && !rst. While rst is asserted, o_in_ready=0.
- Accept condition is i_in_valid && o_in_ready. On accept, latch all inputs.
- Accepted bundle with neither MemRead nor MemWrite:
  - Go to DONE with o_reg_wr_data = i_reg_wr_data.
  - o_out_valid rises the cycle after accept (1-cycle latency).
- Accepted bundle with MemRead or MemWrite: check for a fault.
  - Misaligned access faults: halfword with addr[0]≠0; word with addr[1:0]≠0; doubleword with addr[2:0]≠0.
  - Unsupported encodings fault: load FUNCT3=111; store FUNCT3[2]=1.
  - On fault: go to DONE, o_lsu_fault=1, o_RegWrite=0, no bus activity.
  - Otherwise go to REQ.
- MemRead and MemWrite both set: the bundle is handled as a store.
- REQ:
  - o_mem_req_valid=1, with addr/wen/wdata/wstrb stable until i_mem_req_ready.
  - When i_mem_req_ready is sampled high, go to RESP; o_mem_req_valid drops the next cycle.
- RESP:
  - Wait for i_mem_resp_valid; the earliest response is the cycle after the request handshake.
  - On the response, capture the load result and go to DONE.
  - i_mem_resp_valid is ignored in every state other than RESP.
- Load formatting:
  - Shift i_mem_rdata right by addr[2:0]*8.
  - FUNCT3 000 LB and 001 LH: sign-extend 8/16 bits. 010 LW: sign-extend 32 bits. 011 LD: all 64 bits.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
- Store formatting:
  - Base strobe by size: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF. wstrb = base << addr[2:0].
  - wdata = i_wr_data << (addr[2:0]*8).
  - Stores force o_RegWrite=0. DONE is entered on the write ack.
- DONE:
  - o_out_valid=1 and the output bundle is held stable until i_out_ready.
  - On handshake, go to IDLE. The next accept is possible the following cycle; no in/out bypass.
- Asynchronous reset mid-operation: immediate return to IDLE; o_mem_req_valid and o_out_valid drop without waiting for a clock. A late response arriving after reset is ignored.

Test Plan:
- LB at addr 0x8000_0003, rdata 0x0000_0000_8000_0000 → wstrb=0 and wen=0 on the request; o_reg_wr_data=0xFFFF_FFFF_FFFF_FF80; o_RegWrite=1.
- SH at addr 0x8000_0006, i_wr_data=0x1234 → o_mem_wstrb=0xC0, o_mem_wdata=0x1234_0000_0000_0000, o_mem_addr=0x8000_0000. After the ack, o_out_valid=1 with o_RegWrite=0.
- LW at addr 0x8000_0002 → no o_mem_req_valid. The cycle after accept, o_out_valid=1, o_lsu_fault=1, o_RegWrite=0.
- Back-pressure: hold i_mem_req_ready=0 for 3 cycles, then hold i_out_ready=0 for 2 cycles → request and output fields stay stable throughout; o_in_ready=0 until the output handshake completes.
- Non-memory op with i_reg_wr_data=0x55 and i_out_ready=1 → o_out_valid=1 the next cycle with data 0x55; o_in_ready returns to 1 the cycle after that.
- Assert rst while in RESP, then pulse i_mem_resp_valid after reset is released → FSM in IDLE, all outputs 0, o_out_valid never asserted.

Source files
------------

// File: rtl/ysyx_22040386_lsu.sv
// MEM-stage load/store unit: one outstanding data-bus access, load alignment/extension,
// store strobe generation and a valid/ready writeback output bundle.
module ysyx_22040386_lsu #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [2:0]        i_FUNCT3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [4:0]        i_reg_wr_addr,
  input  logic              i_RegWrite,
  input  logic [DATA_W-1:0] i_reg_wr_data,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [7:0]        o_mem_wstrb,
  input  logic              i_mem_resp_valid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [4:0]        o_reg_wr_addr,
  output logic              o_RegWrite,
  output logic [DATA_W-1:0] o_reg_wr_data,
  output logic              o_lsu_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rd_q, rd_d;
  logic                store_q, store_d;
  logic                load_q, load_d;
  logic                regwrite_q, regwrite_d;
  logic                fault_q, fault_d;

  logic                accept;
  logic                mem_op;
  logic                misaligned;
  logic                unsupported;
  logic                acc_fault;
  logic [DATA_W-1:0]   rdata_sh;
  logic [DATA_W-1:0]   load_data;
  logic [7:0]          base_strb;

  assign o_in_ready = (state_q == StIdle) && !rst;
  assign accept     = i_in_valid && o_in_ready;
  assign mem_op     = i_MemRead || i_MemWrite;

  // Fault decode is done on the incoming bundle so the decision is made at accept time.
  always_comb begin
    misaligned = 1'b0;
    unique case (i_FUNCT3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_addr[0];
      2'b10:   misaligned = |i_addr[1:0];
      default: misaligned = |i_addr[2:0];
    endcase
    unsupported = i_MemWrite ? i_FUNCT3[2] : (i_FUNCT3 == 3'b111);
    acc_fault   = mem_op && (misaligned || unsupported);
  end

  always_comb begin
    rdata_sh  = i_mem_rdata >> {addr_q[2:0], 3'b000};
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  load_data = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_data = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      3'b011:  load_data = rdata_sh;
      3'b100:  load_data = {56'd0, rdata_sh[7:0]};
      3'b101:  load_data = {48'd0, rdata_sh[15:0]};
      3'b110:  load_data = {32'd0, rdata_sh[31:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    store_d    = store_q;
    load_d     = load_q;
    regwrite_d = regwrite_q;
    fault_d    = fault_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d     = i_addr;
          wdata_d    = i_wr_data;
          result_d   = i_reg_wr_data;
          f3_d       = i_FUNCT3;
          rd_d       = i_reg_wr_addr;
          store_d    = i_MemWrite;
          load_d     = i_MemRead && !i_MemWrite;
          fault_d    = acc_fault;
          regwrite_d = i_RegWrite && !i_MemWrite && !acc_fault;
          state_d    = (mem_op && !acc_fault) ? StReq : StDone;
        end
      end
      StReq: begin
        if (i_mem_req_ready) state_d = StResp;
      end
      StResp: begin
        if (i_mem_resp_valid) begin
          if (load_q) result_d = load_data;
          state_d = StDone;
        end
      end
      default: begin
        if (i_out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      store_q    <= 1'b0;
      load_q     <= 1'b0;
      regwrite_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      store_q    <= store_d;
      load_q     <= load_d;
      regwrite_q <= regwrite_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    base_strb = 8'h00;
    unique case (f3_q[1:0])
      2'b00:   base_strb = 8'h01;
      2'b01:   base_strb = 8'h03;
      2'b10:   base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
  end

  assign o_mem_req_valid = (state_q == StReq);
  assign o_mem_wen       = store_q;
  assign o_mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
  assign o_mem_wstrb     = store_q ? (base_strb << addr_q[2:0]) : 8'h00;
  assign o_mem_wdata     = store_q ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
  assign o_out_valid     = (state_q == StDone);
  assign o_reg_wr_addr   = rd_q;
  assign o_RegWrite      = regwrite_q;
  assign o_reg_wr_data   = result_q;
  assign o_lsu_fault     = fault_q;

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Self-checking bench for ysyx_22040386_lsu: scenario tasks, writeback scoreboard queue.
module tb_ysyx_22040386_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic        i_MemRead = 1'b0;
  logic        i_MemWrite = 1'b0;
  logic [2:0]  i_FUNCT3 = '0;
  logic [63:0] i_addr = '0;
  logic [63:0] i_wr_data = '0;
  logic [4:0]  i_reg_wr_addr = '0;
  logic        i_RegWrite = 1'b0;
  logic [63:0] i_reg_wr_data = '0;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic        o_mem_wen;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_resp_valid = 1'b0;
  logic [63:0] i_mem_rdata = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [4:0]  o_reg_wr_addr;
  logic        o_RegWrite;
  logic [63:0] o_reg_wr_data;
  logic        o_lsu_fault;

  always #5 clk = ~clk;

  ysyx_22040386_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .i_MemRead        (i_MemRead),
    .i_MemWrite       (i_MemWrite),
    .i_FUNCT3         (i_FUNCT3),
    .i_addr           (i_addr),
    .i_wr_data        (i_wr_data),
    .i_reg_wr_addr    (i_reg_wr_addr),
    .i_RegWrite       (i_RegWrite),
    .i_reg_wr_data    (i_reg_wr_data),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_wen        (o_mem_wen),
    .o_mem_addr       (o_mem_addr),
    .o_mem_wdata      (o_mem_wdata),
    .o_mem_wstrb      (o_mem_wstrb),
    .i_mem_resp_valid (i_mem_resp_valid),
    .i_mem_rdata      (i_mem_rdata),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_reg_wr_addr    (o_reg_wr_addr),
    .o_RegWrite       (o_RegWrite),
    .o_reg_wr_data    (o_reg_wr_data),
    .o_lsu_fault      (o_lsu_fault)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] data;
    logic        fault;
    bit          chk_data;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Called just after a negedge with the DUT idle; returns one negedge after the accept.
  task automatic send(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rdst,
                      input logic rw, input logic [63:0] rwd);
    i_in_valid    = 1'b1;
    i_MemRead     = rd_en;
    i_MemWrite    = wr_en;
    i_FUNCT3      = f3;
    i_addr        = addr;
    i_wr_data     = wd;
    i_reg_wr_addr = rdst;
    i_RegWrite    = rw;
    i_reg_wr_data = rwd;
    @(negedge clk);
    i_in_valid = 1'b0;
    i_MemRead  = 1'b0;
    i_MemWrite = 1'b0;
  endtask

  // Bus slave: grabs the request fields, acks it, responds the following cycle.
  task automatic mem_serve(input logic [63:0] rdata, output logic [63:0] a,
                           output logic [63:0] w, output logic [7:0] s, output logic wen,
                           output bit to);
    to = 1'b1;
    a = '0; w = '0; s = '0; wen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_mem_req_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (to) return;
    a   = o_mem_addr;
    w   = o_mem_wdata;
    s   = o_mem_wstrb;
    wen = o_mem_wen;
    i_mem_req_ready = 1'b1;
    @(negedge clk);
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = rdata;
    @(negedge clk);
    i_mem_resp_valid = 1'b0;
  endtask

  task automatic wait_out(output wb_t o, output bit to);
    to = 1'b1;
    o  = '{default: '0};
    for (int i = 0; i < 20; i++) begin
      if (o_out_valid) begin
        o.rd    = o_reg_wr_addr;
        o.rw    = o_RegWrite;
        o.data  = o_reg_wr_data;
        o.fault = o_lsu_fault;
        to = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_in_ready, o_mem_req_valid, o_out_valid, o_mem_wen, o_mem_wstrb, o_mem_addr,
         o_mem_wdata, o_reg_wr_addr, o_RegWrite, o_reg_wr_data, o_lsu_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got in_ready=%b req_valid=%b out_valid=%b data=%h, want all 0",
               o_in_ready, o_mem_req_valid, o_out_valid, o_reg_wr_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", o_in_ready);
    end
  endtask

  task automatic test_passthrough();
    wb_t e;
    exp_q.push_back('{rd: 5'd7, rw: 1'b1, data: 64'h55, fault: 1'b0, chk_data: 1'b1});
    i_out_ready = 1'b1;
    send(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd7, 1'b1, 64'h55);
    e = exp_q.pop_front();
    checks++;
    if (o_out_valid !== 1'b1 || o_reg_wr_data !== e.data || o_RegWrite !== e.rw ||
        o_reg_wr_addr !== e.rd || o_lsu_fault !== e.fault || o_mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_out: got valid=%b data=%h rw=%b rd=%0d fault=%b, want 1 %h %b %0d %b",
               o_out_valid, o_reg_wr_data, o_RegWrite, o_reg_wr_addr, o_lsu_fault,
               e.data, e.rw, e.rd, e.fault);
    end
    @(negedge clk);
    i_out_ready = 1'b0;
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_ready: got in_ready=%b out_valid=%b want 1 0",
               o_in_ready, o_out_valid);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s[7]  = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b010, 3'b100, 3'b011};
    logic [63:0] adrs[7] = '{64'h8000_0003, 64'h8000_0012, 64'h8000_0026, 64'h8000_0034,
                             64'h8000_0040, 64'h8000_0051, 64'h8000_0060};
    logic [63:0] rds[7]  = '{64'h0000_0000_8000_0000, 64'hF1E2_D3C4_B5A6_9788,
                             64'hF1E2_D3C4_B5A6_9788, 64'hF1E2_D3C4_B5A6_9788,
                             64'hF1E2_D3C4_B5A6_9788, 64'hF1E2_D3C4_B5A6_9788,
                             64'hF1E2_D3C4_B5A6_9788};
    logic [63:0] res[7]  = '{64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_B5A6,
                             64'h0000_0000_0000_F1E2, 64'h0000_0000_F1E2_D3C4,
                             64'hFFFF_FFFF_B5A6_9788, 64'h0000_0000_0000_0097,
                             64'hF1E2_D3C4_B5A6_9788};
    for (int k = 0; k < 7; k++) begin
      logic [63:0] a, w;
      logic [7:0]  s;
      logic        wen;
      bit          to;
      wb_t         o, e;
      exp_q.push_back('{rd: 5'(k + 1), rw: 1'b1, data: res[k], fault: 1'b0, chk_data: 1'b1});
      send(1'b1, 1'b0, f3s[k], adrs[k], 64'hDEAD, 5'(k + 1), 1'b1, 64'hBAD);
      mem_serve(rds[k], a, w, s, wen, to);
      checks++;
      if (to || wen !== 1'b0 || s !== 8'h00 || a !== {adrs[k][63:3], 3'b000}) begin
        errors++;
        $display("FAIL load[%0d]_req: got to=%0d wen=%b wstrb=%h addr=%h, want 0 0 00 %h",
                 k, to, wen, s, a, {adrs[k][63:3], 3'b000});
      end
      wait_out(o, to);
      e = exp_q.pop_front();
      checks++;
      if (to || o.rd !== e.rd || o.rw !== e.rw || o.data !== e.data || o.fault !== e.fault) begin
        errors++;
        $display("FAIL load[%0d]_wb: got to=%0d rd=%0d rw=%b data=%h fault=%b, want rd=%0d rw=%b data=%h fault=%b",
                 k, to, o.rd, o.rw, o.data, o.fault, e.rd, e.rw, e.data, e.fault);
      end
    end
  endtask

  task automatic test_stores();
    logic        rdb[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s[4]  = '{3'b001, 3'b000, 3'b010, 3'b011};
    logic [63:0] adrs[4] = '{64'h8000_0006, 64'h8000_0105, 64'h8000_020C, 64'h8000_0300};
    logic [63:0] wds[4]  = '{64'h1234, 64'h1111_2222_3333_44AB, 64'hDEAD_BEEF,
                             64'h0102_0304_0506_0708};
    logic [7:0]  strb[4] = '{8'hC0, 8'h20, 8'hF0, 8'hFF};
    logic [63:0] lane[4] = '{64'h1234_0000_0000_0000, 64'h3344_AB00_0000_0000,
                             64'hDEAD_BEEF_0000_0000, 64'h0102_0304_0506_0708};
    for (int k = 0; k < 4; k++) begin
      logic [63:0] a, w;
      logic [7:0]  s;
      logic        wen;
      bit          to;
      wb_t         o, e;
      exp_q.push_back('{rd: 5'(k + 10), rw: 1'b0, data: '0, fault: 1'b0, chk_data: 1'b0});
      send(rdb[k], 1'b1, f3s[k], adrs[k], wds[k], 5'(k + 10), 1'b1, 64'h77);
      mem_serve(64'hFFFF_FFFF_FFFF_FFFF, a, w, s, wen, to);
      checks++;
      if (to || wen !== 1'b1 || s !== strb[k] || w !== lane[k] ||
          a !== {adrs[k][63:3], 3'b000}) begin
        errors++;
        $display("FAIL store[%0d]_req: got to=%0d wen=%b wstrb=%h wdata=%h addr=%h, want 1 %h %h %h",
                 k, to, wen, s, w, a, strb[k], lane[k], {adrs[k][63:3], 3'b000});
      end
      wait_out(o, to);
      e = exp_q.pop_front();
      checks++;
      if (to || o.rd !== e.rd || o.rw !== e.rw || o.fault !== e.fault) begin
        errors++;
        $display("FAIL store[%0d]_wb: got to=%0d rd=%0d rw=%b fault=%b, want %0d %b %b",
                 k, to, o.rd, o.rw, o.fault, e.rd, e.rw, e.fault);
      end
    end
  endtask

  task automatic test_faults();
    logic        rdb[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        wrb[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s[5]  = '{3'b010, 3'b011, 3'b100, 3'b111, 3'b001};
    logic [63:0] adrs[5] = '{64'h8000_0002, 64'h8000_0004, 64'h8000_0000, 64'h8000_0000,
                             64'h8000_0001};
    for (int k = 0; k < 5; k++) begin
      wb_t e;
      exp_q.push_back('{rd: 5'(k + 20), rw: 1'b0, data: '0, fault: 1'b1, chk_data: 1'b0});
      send(rdb[k], wrb[k], f3s[k], adrs[k], 64'h99, 5'(k + 20), 1'b1, 64'h66);
      e = exp_q.pop_front();
      checks++;
      if (o_mem_req_valid !== 1'b0 || o_out_valid !== 1'b1 || o_lsu_fault !== e.fault ||
          o_RegWrite !== e.rw || o_reg_wr_addr !== e.rd) begin
        errors++;
        $display("FAIL fault[%0d]: got req_valid=%b out_valid=%b fault=%b rw=%b rd=%0d, want 0 1 1 0 %0d",
                 k, o_mem_req_valid, o_out_valid, o_lsu_fault, o_RegWrite, o_reg_wr_addr, e.rd);
      end
      i_out_ready = 1'b1;
      @(negedge clk);
      i_out_ready = 1'b0;
    end
  endtask

  task automatic test_back_pressure();
    send(1'b0, 1'b1, 3'b010, 64'h8000_000C, 64'hCAFE_F00D, 5'd3, 1'b1, 64'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h8000_0008 || o_mem_wen !== 1'b1 ||
          o_mem_wstrb !== 8'hF0 || o_mem_wdata !== 64'hCAFE_F00D_0000_0000 ||
          o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_req[%0d]: got valid=%b addr=%h wen=%b wstrb=%h wdata=%h in_ready=%b",
                 i, o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wstrb, o_mem_wdata, o_in_ready);
      end
      @(negedge clk);
    end
    i_mem_req_ready = 1'b1;
    @(negedge clk);
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b1;
    @(negedge clk);
    i_mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_out_valid !== 1'b1 || o_reg_wr_addr !== 5'd3 || o_RegWrite !== 1'b0 ||
          o_lsu_fault !== 1'b0 || o_in_ready !== 1'b0 || o_mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_out[%0d]: got out_valid=%b rd=%0d rw=%b fault=%b in_ready=%b req_valid=%b",
                 i, o_out_valid, o_reg_wr_addr, o_RegWrite, o_lsu_fault, o_in_ready,
                 o_mem_req_valid);
      end
      @(negedge clk);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", o_in_ready, o_out_valid);
    end
  endtask

  task automatic test_reset_mid_resp();
    bit seen_valid = 1'b0;
    send(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 5'd9, 1'b1, 64'h0);
    i_mem_req_ready = 1'b1;
    @(negedge clk);
    i_mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_mem_req_valid !== 1'b0 || o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got req_valid=%b out_valid=%b in_ready=%b want 0 0 0",
               o_mem_req_valid, o_out_valid, o_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    i_mem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (o_out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_valid || o_in_ready !== 1'b1 ||
        {o_mem_req_valid, o_out_valid, o_mem_wen, o_mem_wstrb, o_mem_addr, o_mem_wdata,
         o_reg_wr_addr, o_RegWrite, o_reg_wr_data, o_lsu_fault} !== '0) begin
      errors++;
      $display("FAIL rst_late_resp: got seen_valid=%0d in_ready=%b addr=%h data=%h rd=%0d, want 0 1 0 0 0",
               seen_valid, o_in_ready, o_mem_addr, o_reg_wr_data, o_reg_wr_addr);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_faults();
    test_back_pressure();
    test_reset_mid_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
